// File: rtl/sid_pkg.sv
// -----------------------------------------------------------------------------
// sid_pkg
//   Shared definitions for the SID filter multiplier sharing logic.
//   - Operand widths of the filter fixed-point datapath (coefficient, state).
//   - Width of the truncated product returned to the filter step sequencers.
//   - Round-robin selection helper used by the arbiter.
// -----------------------------------------------------------------------------
package sid_pkg;

    // Unsigned cutoff / resonance coefficient width.
    localparam int SID_COEF_W  = 17;
    // Signed filter state operand width (high-pass / band-pass state).
    localparam int SID_STATE_W = 32;
    // Products are truncated to this width; overflow wraps like the filter maths.
    localparam int SID_PROD_W  = 32;
    // Width of the untruncated product of {1'b0,coef} x state.
    localparam int SID_FULL_W  = SID_COEF_W + 1 + SID_STATE_W;

    // Largest supported requester count and the index width that covers it.
    localparam int SID_MAX_REQ = 4;
    localparam int SID_IDX_W   = 2;

    // Result of a round-robin scan: whether anybody won, and who.
    typedef struct packed {
        logic                 valid;
        logic [SID_IDX_W-1:0] idx;
    } rr_pick_t;

    // Scan last+1, last+2, ... (mod nreq) and return the first index whose
    // request bit is set. Bits at or above nreq are ignored.
    function automatic rr_pick_t rr_pick(
        input logic [SID_MAX_REQ-1:0] req,
        input logic [SID_IDX_W-1:0]   last,
        input int                     nreq
    );
        rr_pick_t pick;
        int       cand;
        pick = '0;
        cand = 0;
        for (int k = 1; k <= SID_MAX_REQ; k++) begin
            cand = (int'(last) + k) % nreq;
            if ((k <= nreq) && !pick.valid && req[cand[SID_IDX_W-1:0]]) begin
                pick.valid = 1'b1;
                pick.idx   = cand[SID_IDX_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sid_mult_pipe.sv
// -----------------------------------------------------------------------------
// sid_mult_pipe
//   LAT-stage signed multiplier shared by the SID filter datapaths. The product
//   of signed {1'b0,i_op_a} and signed i_op_b is formed in front of the first
//   register and truncated to its low SID_PROD_W bits; a one-hot requester tag
//   travels alongside so the result is steered back to its owner.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset, clears all stages
//   i_valid  in   an operation is being issued this cycle
//   i_tag    in   one-hot owner of the issued operation (NREQ bits)
//   i_op_a   in   unsigned coefficient (SID_COEF_W bits)
//   i_op_b   in   signed state operand (SID_STATE_W bits)
//   o_tag    out  one-hot owner of the result leaving the last stage, 0 if none
//   o_data   out  truncated product leaving the last stage
//   o_busy   out  any stage holds a valid operation
// -----------------------------------------------------------------------------
module sid_mult_pipe
    import sid_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int LAT  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [NREQ-1:0]        i_tag,
    input  logic [SID_COEF_W-1:0]  i_op_a,
    input  logic [SID_STATE_W-1:0] i_op_b,
    output logic [NREQ-1:0]        o_tag,
    output logic [SID_PROD_W-1:0]  o_data,
    output logic                   o_busy
);

    logic signed [SID_FULL_W-1:0] w_a_ext;
    logic signed [SID_FULL_W-1:0] w_b_ext;
    logic        [SID_PROD_W-1:0] w_prod;

    logic [LAT-1:0]        r_valid;
    logic [NREQ-1:0]       r_tag  [LAT];
    logic [SID_PROD_W-1:0] r_data [LAT];

    // The coefficient is unsigned, so it gets a zero sign bit before the
    // signed multiply; the state operand is sign-extended.
    assign w_a_ext = SID_FULL_W'($signed({1'b0, i_op_a}));
    assign w_b_ext = SID_FULL_W'($signed(i_op_b));
    // Only the low product bits are kept; wrap-around is intentional.
    assign w_prod  = SID_PROD_W'(w_a_ext * w_b_ext);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int s = 0; s < LAT; s++) begin
                r_tag[s]  <= '0;
                r_data[s] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_tag[0]   <= i_valid ? i_tag : '0;
            // Hold the previous result when idle to avoid needless toggling.
            if (i_valid) begin
                r_data[0] <= w_prod;
            end
            for (int s = 1; s < LAT; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_tag[s]   <= r_tag[s-1];
                r_data[s]  <= r_data[s-1];
            end
        end
    end

    assign o_tag  = r_tag[LAT-1];
    assign o_data = r_data[LAT-1];
    assign o_busy = |r_valid;

endmodule

// File: rtl/sid_mult_arbiter.sv
// -----------------------------------------------------------------------------
// sid_mult_arbiter
//   Round-robin arbiter that lets NREQ SID filter datapaths share a single
//   pipelined 17x32 signed multiplier. One requester is granted per cycle; its
//   operands are captured in the grant cycle and the truncated product comes
//   back on rsp_data with a one-hot rsp_valid exactly LAT cycles after gnt.
//
// Optional build macro:
//   SID_MULT_STATS_EN  when defined, per-requester saturating stall counters
//                      count cycles with req[i]=1 and gnt[i]=0. When not
//                      defined, stall_cnt is constant 0 and no flops exist.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   req        in   per-requester request, held with operands until granted
//   op_a       in   per-requester unsigned coefficient, slice i = [17*i+:17]
//   op_b       in   per-requester signed state operand, slice i = [32*i+:32]
//   gnt        out  one-hot single-cycle grant; operands captured this cycle
//   rsp_valid  out  one-hot result strobe for requester i
//   rsp_data   out  low 32 bits of the signed product
//   busy       out  some pipeline stage holds a valid operation
//   stall_cnt  out  per-requester stall counters, slice i = [CNTW*i+:CNTW]
// -----------------------------------------------------------------------------
module sid_mult_arbiter
    import sid_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int LAT  = 2,
    parameter int CNTW = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*SID_COEF_W-1:0]  op_a,
    input  logic [NREQ*SID_STATE_W-1:0] op_b,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             rsp_valid,
    output logic [SID_PROD_W-1:0]       rsp_data,
    output logic                        busy,
    output logic [NREQ*CNTW-1:0]        stall_cnt
);

    genvar gi;

    logic [NREQ-1:0]        r_gnt;
    logic [SID_IDX_W-1:0]   r_last;

    logic [NREQ-1:0]        w_req_eff;
    logic [SID_MAX_REQ-1:0] w_req_pad;
    logic [NREQ-1:0]        w_gnt_next;
    rr_pick_t               w_pick;
    logic                   w_issue;
    logic [SID_COEF_W-1:0]  w_sel_a;
    logic [SID_STATE_W-1:0] w_sel_b;

    // A requester still shows req high during its own grant cycle (it only
    // drops it afterwards), so that cycle's request is masked out; otherwise
    // one held request would be granted twice.
    assign w_req_eff = req & ~r_gnt;

    // Widen to the helper's fixed request width; unused slots never request.
    generate
        for (gi = 0; gi < SID_MAX_REQ; gi++) begin : g_pad
            if (gi < NREQ) begin : g_live
                assign w_req_pad[gi] = w_req_eff[gi];
            end else begin : g_tie
                assign w_req_pad[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_pick = rr_pick(w_req_pad, r_last, NREQ);

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign w_gnt_next[gi] = w_pick.valid && (w_pick.idx == SID_IDX_W'(gi));
        end
    endgenerate

    // Grant register and round-robin pointer. Starting the pointer at the
    // last index makes requester 0 the first winner after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt  <= '0;
            r_last <= SID_IDX_W'(NREQ - 1);
        end else begin
            r_gnt <= w_gnt_next;
            if (w_pick.valid) begin
                r_last <= w_pick.idx;
            end
        end
    end

    // Operand select: r_gnt is one-hot, so an AND-OR mux is sufficient.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_sel_a = w_sel_a | op_a[SID_COEF_W*i +: SID_COEF_W];
                w_sel_b = w_sel_b | op_b[SID_STATE_W*i +: SID_STATE_W];
            end
        end
    end

    assign w_issue = |r_gnt;

    sid_mult_pipe #(
        .NREQ (NREQ),
        .LAT  (LAT)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_issue),
        .i_tag   (r_gnt),
        .i_op_a  (w_sel_a),
        .i_op_b  (w_sel_b),
        .o_tag   (rsp_valid),
        .o_data  (rsp_data),
        .o_busy  (busy)
    );

    assign gnt = r_gnt;

`ifdef SID_MULT_STATS_EN
    // Saturating per-requester wait counters, cleared only by reset.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_stats
            logic [CNTW-1:0] r_stall;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_stall <= '0;
                end else if (req[gi] && !r_gnt[gi] && (r_stall != {CNTW{1'b1}})) begin
                    r_stall <= r_stall + CNTW'(1);
                end
            end
            assign stall_cnt[CNTW*gi +: CNTW] = r_stall;
        end
    endgenerate
`else
    assign stall_cnt = '0;
`endif

endmodule
